cla_pipe_add: RTL and testbench
===============================

Name: cla_pipe_add

Overview:
- Two-stage pipelined carry-lookahead adder. Directly downstream of the gate primitive layer; built from the team's `_and*`, `_or*`, `_xor2` and `_inv` cells.
- Stage 1 adds the low LO_W bits and registers the carry. Stage 2 adds the high bits using that registered carry.
- Valid/ready handshake on both sides. Feeds the registered-ALU datapath.

Parameters:
- WIDTH, 32, operand and sum width; even, >= 8.
- LO_W, 16, width of the stage-1 low slice; 4 <= LO_W < WIDTH, multiple of 4 (4-bit CLA groups).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum.
- co  output  1  carry-out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous, active-low, on reset_n; all state clears immediately on assertion.
- Reset values: out_valid=0, s=0, co=0, ovf=0. in_ready=1 from the first edge after deassertion. Both stage valids=0. All registered data=0.
- Stage 1 register holds:
  - v1;
  - low sum s_lo[LO_W-1:0];
  - carry c_lo (carry out of bit LO_W-1);
  - a_hi, b_hi (the high WIDTH-LO_W bits).
- Stage 2 register holds: v2, full s, co, ovf. These registers drive out_valid, s, co and ovf directly.
- Adder structure: carry-lookahead within 4-bit groups; group carries rippled between groups inside each stage. Combinational only between the registers.
- Transfer rules:
  - adv2 = v1 & (~v2 | out_ready).
  - in_ready = ~v1 | adv2.
  - Accept when in_valid & in_ready.
- Stage-1 update each cycle:
  - If accept: load the new beat and set v1=1.
  - Else if adv2: set v1=0.
  - Otherwise hold.
- Stage-2 update each cycle:
  - If adv2: load from stage 1 and set v2=1.
  - Else if out_ready: set v2=0.
  - Otherwise hold.
- Latency and throughput:
  - Latency is 2 cycles from accept to out_valid when the consumer is not stalling.
  - Throughput is 1 beat/cycle with out_ready held high.
- Back-pressure:
  - s, co and ovf stay stable while out_valid=1 and out_ready=0.
  - With both stages full and out_ready=0, in_ready=0.
  - No beat is dropped or duplicated.
- Simultaneous events:
  - Accept and adv2 in the same cycle: stage 1 takes the new beat while its old contents move to stage 2.
  - out_ready=1 with v2=1 and adv2: stage 2 is replaced in the same edge.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - Worked example: 0xFFFFFFFF+0x00000001, ci=0 gives s=0, co=1, ovf=0.
  - ovf is computed in stage 2 from the MSB-1 carry.
- Reset mid-operation: in-flight beats are discarded; no output appears after reset_n deasserts.
- Idle inputs: a, b and ci are don't-care when in_valid=0. Registers load only on accept.

Optional Feature:
- Macro: CLA_SAT_EN.
- When defined, stage 2 saturates on signed overflow:
  - If ovf=1 and the MSB of a_hi is 0: s=0x7FFF_FFFF (generally 2^(WIDTH-1)-1).
  - If ovf=1 and the MSB of a_hi is 1: s=0x8000_0000.
  - co and ovf are still reported unmodified.
- When undefined, s always wraps. There is no saturation logic or extra muxing.

Test Plan:
- Reset then single beat: a=0x0000FFFF, b=0x00000001, ci=0 accepted at cycle N -> out_valid at N+2 with s=0x00010000, co=0, ovf=0. This exercises the c_lo handoff.
- Wrap case: a=0xFFFFFFFF, b=0x00000000, ci=1 -> s=0x00000000, co=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 -> ovf=1, co=0.
  - s=0x80000000 without CLA_SAT_EN.
  - s=0x7FFFFFFF with CLA_SAT_EN.
- Streaming: 8 back-to-back beats (a=i, b=i<<16) with out_ready=1 -> 8 consecutive results from N+2, in order, s=i|(i<<16); in_ready never drops.
- Back-pressure: hold out_ready=0 for 4 cycles while in_valid=1 -> in_ready falls after 2 accepts. s stays stable. Releasing out_ready drains in order with no loss or duplicate.
- Async reset: assert reset_n=0 mid-clock with both stages full -> out_valid=0, s=0 immediately. After deassert there is no stale output and in_ready=1.

Source files
------------

// File: rtl/cla_pipe_add.sv
// cla_pipe_add: two-stage pipelined carry-lookahead adder with valid/ready handshake on both sides.
// Optional macro CLA_SAT_EN: stage 2 clamps the sum to the signed limit on overflow.
module cla_pipe_add #(
    parameter int WIDTH = 32,
    parameter int LO_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int HI_W  = WIDTH - LO_W;
    localparam int LO_G  = LO_W / 4;
    localparam int HI_G  = (HI_W + 3) / 4;
    localparam int HI_PW = HI_G * 4;

    // Two-level lookahead for one 4-bit group; returns carries out of bits 0..3.
    function automatic logic [3:0] cla4(
        input logic [3:0] p,
        input logic [3:0] g,
        input logic       cin
    );
        logic [3:0] c;
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    logic            v1;
    logic [LO_W-1:0] s_lo_q;
    logic            c_lo_q;
    logic [HI_W-1:0] a_hi_q;
    logic [HI_W-1:0] b_hi_q;
    logic            v2;

    logic adv2;
    logic accept;

    assign adv2     = v1 & (~v2 | out_ready);
    assign in_ready = ~v1 | adv2;
    assign accept   = in_valid & in_ready;

    logic [LO_W-1:0] lo_p;
    logic [LO_W-1:0] lo_g;
    logic [LO_W:0]   lo_c;
    logic [LO_W-1:0] lo_sum;

    assign lo_p = a[LO_W-1:0] ^ b[LO_W-1:0];
    assign lo_g = a[LO_W-1:0] & b[LO_W-1:0];

    // Group carries ripple from one 4-bit lookahead block into the next.
    always_comb begin
        lo_c    = '0;
        lo_c[0] = ci;
        for (int gi = 0; gi < LO_G; gi++) begin
            lo_c[4*gi+1 +: 4] = cla4(lo_p[4*gi +: 4], lo_g[4*gi +: 4], lo_c[4*gi]);
        end
    end

    assign lo_sum = lo_p ^ lo_c[LO_W-1:0];

    logic [HI_PW-1:0] hi_p;
    logic [HI_PW-1:0] hi_g;
    logic [HI_PW:0]   hi_c;
    logic [HI_W-1:0]  hi_sum;
    logic             co_d;
    logic             ovf_d;
    logic [WIDTH-1:0] sum_wrap;
    logic [WIDTH-1:0] s_d;
    logic             unused_hi_c;

    // The high slice may end in a partial group; pad bits have p=g=0 so they never carry.
    always_comb begin
        hi_p            = '0;
        hi_g            = '0;
        hi_p[HI_W-1:0]  = a_hi_q ^ b_hi_q;
        hi_g[HI_W-1:0]  = a_hi_q & b_hi_q;
    end

    always_comb begin
        hi_c    = '0;
        hi_c[0] = c_lo_q;
        for (int gi = 0; gi < HI_G; gi++) begin
            hi_c[4*gi+1 +: 4] = cla4(hi_p[4*gi +: 4], hi_g[4*gi +: 4], hi_c[4*gi]);
        end
    end

    assign hi_sum      = hi_p[HI_W-1:0] ^ hi_c[HI_W-1:0];
    assign co_d        = hi_c[HI_W];
    assign ovf_d       = hi_c[HI_W] ^ hi_c[HI_W-1];
    assign sum_wrap    = {hi_sum, s_lo_q};
    assign unused_hi_c = ^hi_c;

`ifdef CLA_SAT_EN
    // Clamp toward the sign of operand A, which matches the sign of both operands on overflow.
    always_comb begin
        s_d = sum_wrap;
        if (ovf_d) begin
            s_d = a_hi_q[HI_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign s_d = sum_wrap;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1     <= 1'b0;
            s_lo_q <= '0;
            c_lo_q <= 1'b0;
            a_hi_q <= '0;
            b_hi_q <= '0;
        end else if (accept) begin
            v1     <= 1'b1;
            s_lo_q <= lo_sum;
            c_lo_q <= lo_c[LO_W];
            a_hi_q <= a[WIDTH-1:LO_W];
            b_hi_q <= b[WIDTH-1:LO_W];
        end else if (adv2) begin
            v1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2  <= 1'b0;
            s   <= '0;
            co  <= 1'b0;
            ovf <= 1'b0;
        end else if (adv2) begin
            v2  <= 1'b1;
            s   <= s_d;
            co  <= co_d;
            ovf <= ovf_d;
        end else if (out_ready) begin
            v2 <= 1'b0;
        end
    end

    assign out_valid = v2;

endmodule

// File: tb/tb_cla_pipe_add.sv
// tb_cla_pipe_add: directed vector table plus streaming, back-pressure and async-reset sequences.
// Expected sums follow the CLA_SAT_EN setting of the build.
module tb_cla_pipe_add;

`ifdef CLA_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        co;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cla_pipe_add #(.WIDTH(32), .LO_W(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .ci       (ci),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .co       (co),
        .ovf      (ovf)
    );

    function automatic logic [31:0] satAdj(input logic [31:0] xa, input logic [31:0] xs, input logic xovf);
        if (SAT && xovf) return xa[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return xs;
    endfunction

    // Reference result from plain 33-bit addition and the operand/result sign rule.
    function automatic vec_t model(input logic [31:0] xa, input logic [31:0] xb, input logic xci);
        vec_t  r;
        logic [32:0] full;
        full  = {1'b0, xa} + {1'b0, xb} + {32'b0, xci};
        r.a   = xa;
        r.b   = xb;
        r.ci  = xci;
        r.co  = full[32];
        r.ovf = (xa[31] == xb[31]) && (full[31] != xa[31]);
        r.s   = satAdj(xa, full[31:0], r.ovf);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] xa, input logic [31:0] xb,
                                 input logic xci, input logic rdy);
        in_valid  = v;
        a         = xa;
        b         = xb;
        ci        = xci;
        out_ready = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic checkResult(input string name, input vec_t e);
        checkOutput({name, " out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, " s"}, s, e.s);
        checkOutput({name, " co"}, 32'(co), 32'(e.co));
        checkOutput({name, " ovf"}, 32'(ovf), 32'(e.ovf));
    endtask

    vec_t vecs[11];
    vec_t sb[$];
    vec_t e;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Hand-computed wrapped results; satAdj folds in saturation when enabled.
        vecs[0]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[5]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
        vecs[6]  = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 32'h0001_FFFF, 1'b0, 1'b0};
        vecs[7]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[8]  = '{32'h7FFF_0000, 32'h0001_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vecs[10] = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) vecs[i].s = satAdj(vecs[i].a, vecs[i].s, vecs[i].ovf);

        reset_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset s", s, 32'h0);
        checkOutput("reset co", 32'(co), 32'd0);
        checkOutput("reset ovf", 32'(ovf), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("post-reset out_valid", 32'(out_valid), 32'd0);

        // Single beats: accept, one empty cycle, result on the second edge.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].ci, 1'b1);
            checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
            tick();
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            checkOutput($sformatf("vec%0d early out_valid", i), 32'(out_valid), 32'd0);
            tick();
            checkResult($sformatf("vec%0d", i), vecs[i]);
            tick();
        end

        // Eight back-to-back beats with the consumer always ready.
        for (int t = 0; t < 10; t++) begin
            if (t < 8) begin
                applyStimulus(1'b1, 32'(t + 1), 32'(t + 1) << 16, 1'b0, 1'b1);
                checkOutput($sformatf("stream in_ready t%0d", t), 32'(in_ready), 32'd1);
            end else begin
                applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            end
            tick();
            if (t >= 1 && t <= 8) begin
                checkOutput($sformatf("stream out_valid t%0d", t), 32'(out_valid), 32'd1);
                checkOutput($sformatf("stream s t%0d", t), s, 32'(t) | (32'(t) << 16));
            end else begin
                checkOutput($sformatf("stream idle out_valid t%0d", t), 32'(out_valid), 32'd0);
            end
        end

        // Back-pressure: consumer stalls while the producer keeps offering beats.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 32'h0001_1111 * 32'(c + 1), 32'h0000_FFFF, 1'(c), 1'b0);
            checkOutput($sformatf("bp in_ready c%0d", c), 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
            if (in_ready) sb.push_back(model(a, b, ci));
            tick();
            if (c >= 1) checkResult($sformatf("bp hold c%0d", c), sb[0]);
        end
        checkOutput("bp accepted", 32'(sb.size()), 32'd2);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 8 && sb.size() != 0; k++) begin
            if (out_valid) begin
                e = sb.pop_front();
                checkResult($sformatf("bp drain k%0d", k), e);
            end
            tick();
        end
        checkOutput("bp drain left", 32'(sb.size()), 32'd0);
        checkOutput("bp no duplicate", 32'(out_valid), 32'd0);

        // Async reset mid-cycle with both stages full.
        applyStimulus(1'b1, 32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0);
        e = model(a, b, ci);
        tick();
        applyStimulus(1'b1, 32'h0000_5678, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkResult("prefill", e);
        checkOutput("prefill in_ready", 32'(in_ready), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async out_valid", 32'(out_valid), 32'd0);
        checkOutput("async s", s, 32'h0);
        checkOutput("async co", 32'(co), 32'd0);
        checkOutput("async in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("after reset out_valid k%0d", k), 32'(out_valid), 32'd0);
            checkOutput($sformatf("after reset in_ready k%0d", k), 32'(in_ready), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
